pong_game_ctrl: RTL

Top-level game sequencer for the pong demo. It sits directly upstream of the graphics/ball engine and consumes that engine's miss and score outputs.
- Drives the engine's graph_still freeze input.
- Counts remaining balls and times serve and game-over pauses in video frames.
- Tracks the session best rally score.
- Exposes a state code for the text/overlay stage.

---
 rtl/pong_game_ctrl_if.sv | 27 ++
 rtl/pong_game_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/pong_game_ctrl_if.sv
// Pong sequencer bus: buttons, sync position, engine status in; freeze/overlay state out.
interface pong_game_ctrl_if;
    logic [1:0] btn1;
    logic [1:0] btn2;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       miss;
    logic       hit_left;
    logic       hit_right;
    logic [7:0] left_score;
    logic [7:0] right_score;
    logic       graph_still;
    logic       game_over;
    logic [1:0] balls_left;
    logic [1:0] text_sel;
    logic [7:0] best_score;

    modport master (
        output btn1, btn2, pix_x, pix_y, miss, hit_left, hit_right, left_score, right_score,
        input  graph_still, game_over, balls_left, text_sel, best_score
    );

    modport slave (
        input  btn1, btn2, pix_x, pix_y, miss, hit_left, hit_right, left_score, right_score,
        output graph_still, game_over, balls_left, text_sel, best_score
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/game-over pauses, ball count, session best score.
// Latency: all state changes one clock after the qualifying input; outputs are Moore.
// No backpressure: inputs are levels/pulses sampled every clock.
module pong_game_ctrl #(
    parameter int BALLS        = 3,
    parameter int TIMER_FRAMES = 120,
    parameter int TW           = 10
) (
    input logic           clk,
    input logic           reset,
    pong_game_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_PLAY    = 2'b01;
    localparam logic [1:0] S_NEWBALL = 2'b10;
    localparam logic [1:0] S_OVER    = 2'b11;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_FRAMES);
    localparam logic [1:0]    BALLS_INIT = 2'(BALLS);

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [1:0]    balls_left_q;
    logic [7:0]    best_q;
    logic          miss_d;

    logic       refr_tick;
    logic       btn_any;
    logic       miss_pulse;
    logic [7:0] lr_max;
    logic [7:0] best_next;

    // One-clock pulse at the start of vertical blanking marks a frame boundary.
    assign refr_tick  = (bus.pix_y == 10'd481) && (bus.pix_x == 10'd0);
    assign btn_any    = (|bus.btn1) | (|bus.btn2);
    assign miss_pulse = bus.miss & ~miss_d;
    assign lr_max     = (bus.left_score > bus.right_score) ? bus.left_score : bus.right_score;
    assign best_next  = (lr_max > best_q) ? lr_max : best_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            balls_left_q <= BALLS_INIT;
            best_q       <= 8'h00;
            miss_d       <= 1'b0;
        end else begin
            miss_d <= bus.miss;
            case (state)
                S_IDLE: begin
                    if (refr_tick && btn_any)
                        state <= S_PLAY;
                end
                S_PLAY: begin
                    best_q <= best_next;
                    // A miss wins over a coincident tick: the pause starts with a full load.
                    if (miss_pulse) begin
                        timer <= TIMER_LOAD;
                        if (balls_left_q > 2'd1) begin
                            balls_left_q <= balls_left_q - 2'd1;
                            state        <= S_NEWBALL;
                        end else begin
                            balls_left_q <= 2'd0;
                            state        <= S_OVER;
                        end
                    end
                end
                S_NEWBALL, S_OVER: begin
                    if (refr_tick) begin
                        if (timer == TW'(1)) begin
                            timer <= '0;
                            if (state == S_OVER) begin
                                state        <= S_IDLE;
                                balls_left_q <= BALLS_INIT;
                            end else begin
                                state <= S_PLAY;
                            end
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.graph_still = (state != S_PLAY);
    assign bus.game_over   = (state == S_OVER);
    assign bus.text_sel    = state;
    assign bus.balls_left  = balls_left_q;
    assign bus.best_score  = best_q;
endmodule
